// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - EX-stage operand forwarding select for one source register
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_w_i,
    input  logic [4:0] rd_w_i,
    output logic [1:0] fwd_o
);

    // The MEM result is younger than the WB result, so it wins when both match.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control with dmem wait FSM; HAZ_PERF_CNT_EN adds perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic       RegWriteM,
    input  logic [4:0] RdM,
    input  logic       RegWriteW,
    input  logic [4:0] RdW,
    input  logic       MemReqM,
    input  logic       DmemReady,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_lw_stalls,
    output logic [31:0] perf_mem_stalls,
    output logic [31:0] perf_flushes
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             lw_stall;
    logic             mem_stall;
    logic [1:0]       fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .rs_e_i        (Rs1E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RdM),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RdW),
        .fwd_o         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_e_i        (Rs2E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RdM),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RdW),
        .fwd_o         (fwd_b)
    );

    assign lw_stall  = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = ((state_q == ST_IDLE) && MemReqM && !DmemReady) ||
                       ((state_q == ST_WAIT) && !DmemReady);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Timeout only flags the stuck access; the FSM keeps waiting for DmemReady.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q | ((state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(MAX_WAIT)));
        case (state_q)
            ST_IDLE: begin
                if (MemReqM && !DmemReady) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (DmemReady) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // A memory stall freezes every stage, so pending flushes wait for the release cycle.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushE = lw_stall | PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lw_q, perf_mem_q, perf_fl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw_q  <= '0;
            perf_mem_q <= '0;
            perf_fl_q  <= '0;
        end else begin
            if (lw_stall && !mem_stall) perf_lw_q <= perf_lw_q + 32'd1;
            if (mem_stall)              perf_mem_q <= perf_mem_q + 32'd1;
            if (PCSrcE && !mem_stall)   perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign perf_lw_stalls  = perf_lw_q;
    assign perf_mem_stalls = perf_mem_q;
    assign perf_flushes    = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MAX_WAIT=4)
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, DmemReady;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lw_stalls, perf_mem_stalls, perf_flushes;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .MemReqM(MemReqM), .DmemReady(DmemReady),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_lw_stalls(perf_lw_stalls), .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, mem_timeout}
    function automatic logic [11:0] obs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_timeout};
    endfunction

    function automatic logic [11:0] ev(logic [3:0] stl, logic [2:0] fl, logic [1:0] fa, logic [1:0] fb, logic to);
        return {stl, fl, fa, fb, to};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        MemReadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; DmemReady = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle_inputs();
            e.name = "reset";
            if (i < 2) begin
                rst = 1'b1; MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
                RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3; MemReqM = 1'b1;
            end
            e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle_inputs();
            RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd9;
            e.name = "forward";
            case (i)
                0: e.v = ev(4'b0000, 3'b000, FWD_M, FWD_RF, 1'b0);
                1: begin RdW = 5'd9; e.v = ev(4'b0000, 3'b000, FWD_M, FWD_W, 1'b0); end
                2: begin RegWriteM = 1'b0; e.v = ev(4'b0000, 3'b000, FWD_W, FWD_RF, 1'b0); end
                3: begin RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0); end
                default: begin RegWriteW = 1'b0; RdM = 5'd3; Rs2E = 5'd3; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_M, 1'b0); end
            endcase
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle_inputs();
            e.name = "load_use";
            case (i)
                0: begin MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; e.v = ev(4'b1100, 3'b010, FWD_RF, FWD_RF, 1'b0); end
                1: e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
                2: begin MemReadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0); end
                3: begin RdE = 5'd7; Rs1D = 5'd7; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0); end
                default: begin MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; e.v = ev(4'b1100, 3'b010, FWD_RF, FWD_RF, 1'b0); end
            endcase
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle_inputs();
            e.name = "branch";
            PCSrcE = (i == 0);
            e.v = (i == 0) ? ev(4'b0000, 3'b110, FWD_RF, FWD_RF, 1'b0) : ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_mem_wait();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 11; i++) begin
            next_cycle(); idle_inputs();
            e.name = "mem_wait";
            case (i)
                0, 1, 2: begin MemReqM = 1'b1; e.v = ev(4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0); end
                3: begin MemReqM = 1'b1; DmemReady = 1'b1; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0); end
                5, 6, 7: begin MemReqM = 1'b1; PCSrcE = 1'b1; e.v = ev(4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0); end
                8: begin MemReqM = 1'b1; PCSrcE = 1'b1; DmemReady = 1'b1; e.v = ev(4'b0000, 3'b110, FWD_RF, FWD_RF, 1'b0); end
                9: begin MemReqM = 1'b1; DmemReady = 1'b1; e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0); end
                default: e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            endcase
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 10; i++) begin
            next_cycle(); idle_inputs();
            e.name = "timeout";
            if (i <= 5) begin
                MemReqM = 1'b1;
                e.v = ev(4'b1111, 3'b001, FWD_RF, FWD_RF, i == 5);
            end else if (i == 6) begin
                MemReqM = 1'b1; DmemReady = 1'b1;
                e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b1);
            end else if (i == 7) begin
                e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b1);
            end else if (i == 8) begin
                rst = 1'b1; MemReqM = 1'b1; PCSrcE = 1'b1;
                e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b1);
            end else begin
                e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            end
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle_inputs();
            e.name = "reset_mid_wait";
            case (i)
                0, 1: begin MemReqM = 1'b1; e.v = ev(4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0); end
                2: begin
                    rst = 1'b1; MemReqM = 1'b1; PCSrcE = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
                    MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
                    e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
                end
                default: e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            endcase
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [11:0] got;
        for (int i = 0; i < 6; i++) begin
            next_cycle(); idle_inputs();
            e.name = "back_to_back";
            case (i)
                0: begin MemReadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; PCSrcE = 1'b1; e.v = ev(4'b1100, 3'b110, FWD_RF, FWD_RF, 1'b0); end
                1: begin PCSrcE = 1'b1; e.v = ev(4'b0000, 3'b110, FWD_RF, FWD_RF, 1'b0); end
                2, 3: begin MemReadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; MemReqM = 1'b1; e.v = ev(4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0); end
                4: begin MemReadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; MemReqM = 1'b1; DmemReady = 1'b1; e.v = ev(4'b1100, 3'b010, FWD_RF, FWD_RF, 1'b0); end
                default: e.v = ev(4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0);
            endcase
            sb.push_back(e);
            @(negedge clk); got = obs(); e = sb.pop_front(); n_cmp++;
            if (got !== e.v) begin
                n_err++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, got, e.v);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RISC-V pipeline.
- Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses with a wait-state FSM. A saturating wait counter provides a sticky timeout error.

Parameters:
- MAX_WAIT, 16: wait cycles in WAIT before `mem_timeout` sets (range 1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  5  ID-stage source registers
- Rs1E, Rs2E  in  5  EX-stage source registers
- RdE  in  5  EX-stage destination
- MemReadE  in  1  EX-stage instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- RegWriteM, RdM  in  1, 5  MEM-stage writeback info
- RegWriteW, RdW  in  1, 5  WB-stage writeback info
- MemReqM  in  1  MEM-stage load/store active
- DmemReady  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers
- FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB (insert bubble)
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = WB result, 10 = MEM ALU result
- mem_timeout  out  1  sticky; set when MAX_WAIT is reached

Behaviour:
- Forwarding (combinational), per operand:
  - 10 if RegWriteM && RdM!=0 && RdM==RsxE.
  - Else 01 if RegWriteW && RdW!=0 && RdW==RsxE.
  - Else 00.
  - MEM has priority over WB.
- lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = (state==IDLE && MemReqM && !DmemReady) || (state==WAIT && !DmemReady).
- Output equations when memStall=0:
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - StallE = StallM = FlushW = 0.
- Output equations when memStall=1:
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1.
  - FlushD = FlushE = 0. Frozen stages keep their instructions; a pending lwStall or PCSrcE reasserts naturally on the release cycle.
- FSM state IDLE:
  - MemReqM && !DmemReady -> WAIT, wait_cnt <= 1.
  - Otherwise stay in IDLE.
- FSM state WAIT:
  - DmemReady -> IDLE, wait_cnt <= 0. Release is the same cycle: outputs follow the memStall=0 equations that cycle.
  - Otherwise stay in WAIT; wait_cnt increments, saturating at all-ones.
- mem_timeout sets when state==WAIT && wait_cnt==MAX_WAIT. It stays set until rst. The FSM keeps waiting; there is no forced release.
- Latency: all stall, flush and forward outputs are combinational from the inputs and the registered state, so they are valid in the same cycle. State and counters are updated at the clock edge.
- Reset (any cycle, including mid-WAIT):
  - state <= IDLE, wait_cnt <= 0, mem_timeout <= 0.
  - While rst=1, every stall/flush output is forced to 0 and ForwardAE/BE to 00.
- Simultaneous events:
  - lwStall && PCSrcE: FlushE=1, StallF=StallD=1. The branch redirect is applied once the stall lifts.
  - MemReqM && DmemReady in IDLE: no stall; zero-wait access.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds three 32-bit outputs, all cleared by rst:
  - perf_lw_stalls: increments each cycle with lwStall && !memStall.
  - perf_mem_stalls: increments each memStall cycle.
  - perf_flushes: increments each cycle with PCSrcE && !memStall.
  - The counters wrap at 2^32.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - State encoding: ST_IDLE=1'b0, ST_WAIT=1'b1.
- One sub-module, fwd_sel: combinational forwarding comparator, instantiated twice (operands A and B).

Test Plan:
- Forwarding priority: RdM=5, RdW=5, both RegWrite=1, Rs1E=5 -> ForwardAE=10. Set RegWriteM=0 -> 01. Set RdM=RdW=0 -> 00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0. Repeat with RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1 that cycle only, no stalls.
- Mem wait: MemReqM=1, DmemReady low for 3 cycles then high -> StallF/D/E/M=FlushW=1 for 3 cycles, 0 on the ready cycle, state back to IDLE. Combine with PCSrcE=1 held -> FlushD/E=0 during the wait and 1 on the release cycle.
- Timeout: MAX_WAIT=4, DmemReady held 0 -> mem_timeout rises after 4 WAIT cycles and stays set after DmemReady=1. Assert rst -> cleared, state IDLE.
- Reset mid-WAIT: rst=1 on the 2nd wait cycle -> all outputs 0 that cycle. After rst deasserts with MemReqM=0 -> no stall.
